// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake and line/status signals of the buffered UART transmitter.
interface uart_tx_buffered_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       tx;

  modport master (
    output wr_en, wr_data,
    input  full, empty, busy, overflow, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, busy, overflow, tx
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding an LSB-first serialiser that
// sends queued bytes back-to-back at CLK_HZ/BAUD clocks per bit.
module uart_tx_buffered #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_buffered_if.slave bus
);
  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW     = PtrW + 1;
  localparam logic [CntW-1:0]   BaudLast  = CntW'(ClksPerBit - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CntW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, wr_acc, pop, baud_end;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign wr_acc   = bus.wr_en && !full;
  assign baud_end = (baud_cnt_q == BaudLast);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem[rptr_q];
          tx_d       = 1'b0;
          baud_cnt_d = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          tx_d       = shift_q[0];
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          state_d    = StData;
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            // Shift register keeps the next bit at [1] so tx is loaded on the boundary edge.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d     = wr_acc ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PtrW'(1) : rptr_q;
    overflow_d = bus.wr_en && full;
    count_d    = count_q;
    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= bus.wr_data;
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: a line decoder turns tx back into bytes with frame start cycles, and
// directed plus random write streams are compared against expected byte order and timing.
module tb_uart_tx_buffered;
  localparam int unsigned ClkHz    = 40;
  localparam int unsigned Baud     = 10;
  localparam int unsigned Depth    = 16;
  localparam int unsigned Cpb      = ClkHz / Baud;
  localparam int unsigned FrameLen = 10 * Cpb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int unsigned cyc = 0;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .CLK_HZ     (ClkHz),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: frames captured sample-by-sample, bytes read from each bit slot.
  logic [7:0]  got_q[$];
  bit          ok_q[$];
  int unsigned start_q[$];
  int unsigned n_starts = 0;

  function automatic void decode(input logic [FrameLen-1:0] s, output logic [7:0] b,
                                 output bit ok);
    ok = 1'b1;
    b  = '0;
    for (int g = 0; g < 10; g++)
      for (int j = 1; j < Cpb; j++)
        if (s[g*Cpb+j] !== s[g*Cpb]) ok = 1'b0;
    if (s[0] !== 1'b0 || s[9*Cpb] !== 1'b1) ok = 1'b0;
    for (int i = 0; i < 8; i++) b[i] = s[(i+1)*Cpb];
  endfunction

  initial begin
    bit                in_frame = 1'b0;
    int unsigned       idx = 0;
    int unsigned       mon_start = 0;
    logic [FrameLen-1:0] smp = '0;
    logic [7:0]        b;
    bit                ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (bus.tx === 1'b0) begin
          in_frame  = 1'b1;
          smp[0]    = 1'b0;
          idx       = 1;
          mon_start = cyc;
          n_starts++;
        end
      end else begin
        smp[idx] = bus.tx;
        idx++;
        if (idx == FrameLen) begin
          decode(smp, b, ok);
          got_q.push_back(b);
          ok_q.push_back(ok);
          start_q.push_back(mon_start);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      step();
      t++;
    end
    chk({tag, "_frames_seen"}, 32'(got_q.size() >= n), 1);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] exp_b,
                           input int unsigned exp_start, input bit chk_start);
    int unsigned s;
    chk({tag, "_present"}, 32'(got_q.size() != 0), 1);
    if (got_q.size() != 0) begin
      chk({tag, "_byte"}, got_q.pop_front(), exp_b);
      chk({tag, "_framing"}, ok_q.pop_front(), 1);
      s = start_q.pop_front();
      if (chk_start) chk({tag, "_start"}, s, exp_start);
    end
  endtask

  initial begin
    int unsigned k;
    int          busy_cnt;
    int          t;
    int unsigned base;
    int          outstanding;
    logic [7:0]  exp6[$];
    logic [7:0]  d;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    rst_n       = 1'b0;
    repeat (3) step();
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single byte
    bus.wr_en = 1'b1; bus.wr_data = 8'h41;
    step();
    k = cyc; bus.wr_en = 1'b0;
    chk("t1_empty_after_wr", bus.empty, 0);
    chk("t1_tx_before_pop", bus.tx, 1);
    step();
    chk("t1_tx_start", bus.tx, 0);
    chk("t1_busy_start", bus.busy, 1);
    chk("t1_empty_after_pop", bus.empty, 1);
    busy_cnt = int'(bus.busy);
    repeat (44) begin
      step();
      busy_cnt += int'(bus.busy);
    end
    chk("t1_busy_cycles", busy_cnt, FrameLen);
    chk("t1_tx_idle", bus.tx, 1);
    chk("t1_empty_end", bus.empty, 1);
    chk_frame("t1", 8'h41, k + 1, 1'b1);

    // Back-to-back
    repeat (3) step();
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    step();
    k = cyc; bus.wr_data = 8'hA3;
    step();
    bus.wr_en = 1'b0;
    wait_frames(2, 120, "t2");
    chk_frame("t2_a", 8'h55, k + 1, 1'b1);
    chk_frame("t2_b", 8'hA3, k + 1 + FrameLen, 1'b1);

    // Overflow
    repeat (5) step();
    k = 0;
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      step();
      if (i == 0) k = cyc;
      if (i == 15) chk("t3_not_full_16", bus.full, 0);
      if (i == 16) begin
        chk("t3_full_17", bus.full, 1);
        chk("t3_no_ovf_17", bus.overflow, 0);
      end
      if (i == 17) begin
        chk("t3_ovf_18", bus.overflow, 1);
        chk("t3_full_18", bus.full, 1);
      end
    end
    bus.wr_en = 1'b0;
    step();
    chk("t3_ovf_pulse_end", bus.overflow, 0);
    wait_frames(17, 17 * FrameLen + 100, "t3");
    for (int i = 0; i < 17; i++) chk_frame("t3", 8'(i), k + 1 + FrameLen * i, 1'b1);
    repeat (60) step();
    chk("t3_no_extra", got_q.size(), 0);
    chk("t3_idle_busy", bus.busy, 0);
    chk("t3_idle_empty", bus.empty, 1);

    // Push and pop on the same edge at the end of STOP
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
    step();
    k = cyc; bus.wr_en = 1'b0;
    while (cyc < k + 20) step();
    bus.wr_en = 1'b1; bus.wr_data = 8'h96;
    step();
    bus.wr_en = 1'b0;
    while (cyc < k + FrameLen) step();
    bus.wr_en = 1'b1; bus.wr_data = 8'hE7;
    step();
    bus.wr_en = 1'b0;
    chk("t4_count1_empty", bus.empty, 0);
    chk("t4_count1_full", bus.full, 0);
    chk("t4_busy", bus.busy, 1);
    chk("t4_tx_start", bus.tx, 0);
    wait_frames(3, 3 * FrameLen + 60, "t4");
    chk_frame("t4_a", 8'h3C, k + 1, 1'b1);
    chk_frame("t4_b", 8'h96, k + 1 + FrameLen, 1'b1);
    chk_frame("t4_c", 8'hE7, k + 1 + 2 * FrameLen, 1'b1);
    repeat (50) step();
    chk("t4_no_extra", got_q.size(), 0);
    chk("t4_empty_end", bus.empty, 1);

    // Reset during DATA bit 3 with bytes queued
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h11 + i);
      step();
      if (i == 0) k = cyc + 1;
    end
    bus.wr_en = 1'b0;
    while (cyc < k + 4 * Cpb) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_tx", bus.tx, 1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_empty", bus.empty, 1);
    chk("t5_full", bus.full, 0);
    repeat (100) step();
    chk("t5_no_frames", got_q.size(), 0);
    chk("t5_tx_idle", bus.tx, 1);
    chk("t5_busy_idle", bus.busy, 0);

    // Random stream through the wrapping FIFO, never overfilled
    base = n_starts;
    t = 0;
    while (exp6.size() < 40 && t < 4000) begin
      outstanding = exp6.size() - int'(n_starts - base);
      chk("t6_full", bus.full, 32'(outstanding == Depth));
      chk("t6_empty", bus.empty, 32'(outstanding == 0));
      chk("t6_no_ovf", bus.overflow, 0);
      if (outstanding < Depth && $urandom_range(0, 3) != 0) begin
        d = 8'($urandom);
        bus.wr_en = 1'b1; bus.wr_data = d;
        exp6.push_back(d);
      end else begin
        bus.wr_en = 1'b0;
      end
      step();
      t++;
    end
    bus.wr_en = 1'b0;
    chk("t6_all_written", exp6.size(), 40);
    wait_frames(40, 40 * FrameLen + 200, "t6");
    foreach (exp6[i]) chk_frame("t6", exp6[i], 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
